// File: rtl/shift_reg_univ.sv
// Universal shift register: parallel load plus SRL/SLL/SRA/ROR/ROL, one step per clock.
// Defining SHREG_SERIAL_IN_EN adds the ser_in_r/ser_in_l fill ports; without it, logical shifts fill with 0.
//
// state | meaning
// IDLE  | waiting for ld or start
// RUN   | executing one step per cycle until cnt reaches 1
module shift_reg_univ #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld,
    input  logic [WIDTH-1:0] d_in,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AMT_W-1:0] amt,
`ifdef SHREG_SERIAL_IN_EN
    input  logic             ser_in_r,
    input  logic             ser_in_l,
`endif
    output logic [WIDTH-1:0] q,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    localparam logic IDLE = 1'b0;
    localparam logic RUN  = 1'b1;

    localparam logic [2:0] OP_SRL = 3'd0;
    localparam logic [2:0] OP_SLL = 3'd1;
    localparam logic [2:0] OP_SRA = 3'd2;
    localparam logic [2:0] OP_ROR = 3'd3;
    localparam logic [2:0] OP_ROL = 3'd4;

    localparam logic [AMT_W-1:0] CNT_ZERO = '0;
    localparam logic [AMT_W-1:0] CNT_ONE  = AMT_W'(1);

    logic             state;
    logic [AMT_W-1:0] cnt;
    logic [2:0]       op_r;
    logic             fill_r;
    logic             fill_l;
    logic [WIDTH-1:0] step_q;
    logic             step_so;

    // Fill bits are read live on every step rather than captured at start.
`ifdef SHREG_SERIAL_IN_EN
    assign fill_r = ser_in_r;
    assign fill_l = ser_in_l;
`else
    assign fill_r = 1'b0;
    assign fill_l = 1'b0;
`endif

    always_comb begin
        step_q  = q;
        step_so = ser_out;
        case (op_r)
            OP_SRL: begin
                step_q  = {fill_r, q[WIDTH-1:1]};
                step_so = q[0];
            end
            OP_SLL: begin
                step_q  = {q[WIDTH-2:0], fill_l};
                step_so = q[WIDTH-1];
            end
            OP_SRA: begin
                step_q  = {q[WIDTH-1], q[WIDTH-1:1]};
                step_so = q[0];
            end
            OP_ROR: begin
                step_q  = {q[0], q[WIDTH-1:1]};
                step_so = q[0];
            end
            OP_ROL: begin
                step_q  = {q[WIDTH-2:0], q[WIDTH-1]};
                step_so = q[WIDTH-1];
            end
            default: begin
                step_q  = q;
                step_so = ser_out;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= CNT_ZERO;
            op_r    <= OP_SRL;
            q       <= '0;
            ser_out <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (ld) begin
                        q <= d_in;
                    end else if (start) begin
                        if (amt != CNT_ZERO) begin
                            op_r  <= op;
                            cnt   <= amt;
                            state <= RUN;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // ld aborts the command silently; start is ignored here.
                    if (ld) begin
                        q     <= d_in;
                        cnt   <= CNT_ZERO;
                        state <= IDLE;
                    end else begin
                        q       <= step_q;
                        ser_out <= step_so;
                        cnt     <= cnt - CNT_ONE;
                        if (cnt == CNT_ONE) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == RUN);

endmodule
